param_ctrl_unit: RTL and testbench
==================================

Name: param_ctrl_unit

Overview:
Multi-cycle, parametrised successor of the 8-bit control unit. It accepts one instruction per valid/ready handshake and decodes it with a FSM. It owns a REG_COUNT x DATA_W register file and drives an external ALU through a start/done handshake, with a completion timeout. Results are written back to the register file or presented on a registered output port. It sits between the instruction source (switches/host) and the ALU and display logic.

Parameters:
DATA_W, 8, datapath and register width (>=2).
REG_COUNT, 4, number of registers; power of two, >=2; SEL_W = $clog2(REG_COUNT).
ALU_TIMEOUT, 15, maximum cycles spent in ALU_WAIT before aborting (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  instruction available.
instr_ready  out  1  unit can accept an instruction.
instr  in  4+2*SEL_W  [top 4]=opcode, then rd (SEL_W), then rs (SEL_W, LSBs).
imm_data  in  DATA_W  immediate for LOADI, sampled at acceptance.
alu_start  out  1  one-cycle pulse starting an ALU operation.
alu_op  out  3  ALU function (opcode[2:0]).
alu_a  out  DATA_W  operand A = reg[rd].
alu_b  out  DATA_W  operand B = reg[rs].
alu_done  in  1  ALU result valid (single-cycle pulse).
alu_result  in  DATA_W  ALU result, valid when alu_done=1.
out_data  out  DATA_W  output register.
out_valid  out  1  one-cycle pulse when out_data updates.
busy  out  1  high in any state other than IDLE.
err_illegal  out  1  sticky; set on an illegal opcode.
err_timeout  out  1  sticky; set on an ALU timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers, out_data, alu_a, alu_b, alu_op, counters and error flags = 0; alu_start=0; out_valid=0. Deasserting reset mid-operation leaves the unit in IDLE; no partial writeback survives.
- instr_ready = (state==IDLE); busy = !instr_ready; both combinational from state.
- States: IDLE, DECODE, ALU_WAIT.
- IDLE: on instr_valid&&instr_ready, latch instr and imm_data, then go to DECODE. Otherwise stay in IDLE.
- DECODE (one cycle), by opcode:
  - 0000-0111 (ALU ops: add, sub, mul, div, shl, shr, sq_a, sq_b): register alu_a=reg[rd], alu_b=reg[rs], alu_op=opcode[2:0]. Pulse alu_start for exactly one cycle, which is the first ALU_WAIT cycle. Clear the timeout counter. Go to ALU_WAIT.
  - 1000 MOVE: reg[rd]<=reg[rs]. Go to IDLE.
  - 1001 LOADI: reg[rd]<=latched imm_data. Go to IDLE.
  - 1010 OUT: out_data<=reg[rd]; out_valid=1 for one cycle. Go to IDLE.
  - 1011 NOP: go to IDLE.
  - 1100-1111: set err_illegal; no register change. Go to IDLE.
- ALU_WAIT:
  - If alu_done=1: reg[rd]<=alu_result[DATA_W-1:0], go to IDLE. alu_done is honoured even in the same cycle as alu_start.
  - Else the counter increments. When the counter reaches ALU_TIMEOUT without alu_done, set err_timeout, leave reg[rd] unchanged, and go to IDLE.
  - If alu_done and the timeout coincide, done wins.
  - alu_done while not in ALU_WAIT is ignored.
- Latency from acceptance edge back to instr_ready=1:
  - 2 cycles for MOVE/LOADI/OUT/NOP/illegal.
  - 2+N cycles for ALU ops, where alu_done arrives N cycles into ALU_WAIT.
- rd==rs is legal: MOVE is a no-op write, and ALU ops get identical operands.
- Register writes are visible to the next accepted instruction. No forwarding is needed because issue is serialised.
- Error flags clear only on reset.
- alu_a, alu_b and alu_op hold their values until the next ALU issue.

Test Plan:
1. Reset, then LOADI r1=0x05 and LOADI r2=0x03, then ADD rd=1, rs=2; the ALU model returns 0x08 after 3 cycles -> alu_start pulses once with a=0x05, b=0x03, op=000; r1=0x08; instr_ready returns 5 cycles after acceptance.
2. MOVE r3<=r1, then OUT r3 -> out_data=0x08 with out_valid high for exactly 1 cycle; instr_ready is low for exactly 1 cycle per instruction.
3. Opcode 1110 -> err_illegal=1 and stays set across later valid instructions; the register file is unchanged.
4. SUB with alu_done never asserted, ALU_TIMEOUT=15 -> err_timeout sets after 15 ALU_WAIT cycles, rd is unchanged, and the unit returns to IDLE. Hold instr_valid=1 throughout -> the next instruction is not accepted until instr_ready=1.
5. Pull rst_n low while in ALU_WAIT, then assert alu_done after release -> no writeback, state=IDLE, all outputs 0, instr_ready=1.
6. With DATA_W=16 and REG_COUNT=8: LOADI r7=0xFFFF, then ADD r7,r7 with an ALU model returning 0x1FFFE -> r7=0xFFFE (truncated), and the instruction width is 10 bits.

Source files
------------

// File: rtl/param_ctrl_unit.sv
// Serialised instruction unit: decodes one instruction at a time, owns a small
// register file and drives an external ALU through a start/done handshake with timeout.
module param_ctrl_unit #(
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned REG_COUNT   = 4,
  parameter  int unsigned ALU_TIMEOUT = 15,
  localparam int unsigned SEL_W       = $clog2(REG_COUNT),
  localparam int unsigned INSTR_W     = 4 + 2 * SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  imm_data,
  output logic               alu_start,
  output logic [2:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic               alu_done,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               err_illegal,
  output logic               err_timeout
);

  localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DECODE   = 2'd1,
    S_ALU_WAIT = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [3:0]         op_q,        op_d;
  logic [SEL_W-1:0]   rd_q,        rd_d;
  logic [SEL_W-1:0]   rs_q,        rs_d;
  logic [DATA_W-1:0]  imm_q,       imm_d;
  logic [DATA_W-1:0]  regs_q [REG_COUNT];
  logic [DATA_W-1:0]  regs_d [REG_COUNT];
  logic [DATA_W-1:0]  alu_a_q,     alu_a_d;
  logic [DATA_W-1:0]  alu_b_q,     alu_b_d;
  logic [2:0]         alu_op_q,    alu_op_d;
  logic               alu_start_q, alu_start_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               err_ill_q,   err_ill_d;
  logic               err_to_q,    err_to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      regs_q      <= '{default: '0};
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_ill_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      err_ill_q   <= err_ill_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    err_ill_d   = err_ill_q;
    err_to_d    = err_to_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr[INSTR_W-1 -: 4];
          rd_d    = instr[2*SEL_W-1 -: SEL_W];
          rs_d    = instr[SEL_W-1:0];
          imm_d   = imm_data;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_IDLE;
        if (!op_q[3]) begin
          // alu_start is registered here so it is high during the first wait cycle
          alu_a_d     = regs_q[rd_q];
          alu_b_d     = regs_q[rs_q];
          alu_op_d    = op_q[2:0];
          alu_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_ALU_WAIT;
        end else begin
          case (op_q[2:0])
            3'b000: regs_d[rd_q] = regs_q[rs_q];
            3'b001: regs_d[rd_q] = imm_q;
            3'b010: begin
              out_data_d  = regs_q[rd_q];
              out_valid_d = 1'b1;
            end
            3'b011: ;
            default: err_ill_d = 1'b1;
          endcase
        end
      end

      S_ALU_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (alu_done) begin
          regs_d[rd_q] = alu_result;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = !instr_ready;
  assign alu_start   = alu_start_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_param_ctrl_unit.sv
// Scoreboard bench for param_ctrl_unit: a default 8-bit/4-register instance with a
// behavioural ALU, plus a 16-bit/8-register instance for truncation on writeback.
module tb_param_ctrl_unit;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MOVE = 4'd8,
                         OP_LOADI = 4'd9, OP_OUT = 4'd10, OP_NOP = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] imm_data;
  logic       instr_ready, busy, alu_start, out_valid, err_illegal, err_timeout;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result, out_data;
  logic       done_m, done_inj, alu_done;

  logic        w_valid, w_ready, w_busy, w_start, w_done, w_out_valid, w_ill, w_to;
  logic [9:0]  w_instr;
  logic [15:0] w_imm, w_a, w_b, w_out_data;
  logic [16:0] w_res_full;
  logic [2:0]  w_op;

  int n_checks = 0;
  int n_pass   = 0;
  int resp_delay;
  int start_cnt = 0;
  logic [7:0]  shadow [4];
  logic [7:0]  exp_out_q [$];
  logic [18:0] exp_alu_q [$];
  logic [18:0] alu_exp;
  logic [7:0]  out_exp;

  assign alu_done = done_m | done_inj;

  param_ctrl_unit u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm_data(imm_data), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  param_ctrl_unit #(.DATA_W(16), .REG_COUNT(8), .ALU_TIMEOUT(15)) u_wide (
    .clk(clk), .rst_n(rst_n), .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .imm_data(w_imm), .alu_start(w_start), .alu_op(w_op),
    .alu_a(w_a), .alu_b(w_b), .alu_done(w_done), .alu_result(w_res_full[15:0]),
    .out_data(w_out_data), .out_valid(w_out_valid), .busy(w_busy),
    .err_illegal(w_ill), .err_timeout(w_to)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return 8'(a * b);
      3'd3: return (b == 8'd0) ? 8'd0 : a / b;
      3'd4: return a << b[2:0];
      3'd5: return a >> b[2:0];
      3'd6: return 8'(a * a);
      default: return 8'(b * b);
    endcase
  endfunction

  // Behavioural ALU: done lands in the resp_delay-th wait cycle (1 = alongside start)
  initial begin
    done_m = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_start && resp_delay > 0) begin
        for (int i = 1; i < resp_delay; i++) @(negedge clk);
        done_m     = 1'b1;
        alu_result = alu_fn(alu_op, alu_a, alu_b);
        @(negedge clk);
        done_m = 1'b0;
      end
    end
  end

  // Scoreboard: pop expectations as the DUT emits issue and output pulses
  always @(negedge clk) begin
    if (alu_start) begin
      start_cnt++;
      if (exp_alu_q.size() == 0) check("alu_start_unexpected", 32'd1, 32'd0);
      else begin
        alu_exp = exp_alu_q.pop_front();
        check("alu_issue", {13'd0, alu_op, alu_a, alu_b}, {13'd0, alu_exp});
      end
    end
    if (out_valid) begin
      if (exp_out_q.size() == 0) check("out_valid_unexpected", 32'd1, 32'd0);
      else begin
        out_exp = exp_out_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, out_exp});
      end
    end
  end

  // Presents an instruction (valid stays high) and returns the busy cycles waited
  task automatic issue(input logic [3:0] op, input int rd, input int rs,
                       input logic [7:0] imm, output int lows);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = {op, 2'(rd), 2'(rs)};
    imm_data    = imm;
    lows        = 0;
    while (!instr_ready && lows < 200) begin
      lows++;
      @(negedge clk);
    end
    if (!instr_ready) check("ready_wait_expired", 32'd0, 32'd1);
    if (!op[3]) begin
      exp_alu_q.push_back({op[2:0], shadow[rd], shadow[rs]});
      if (resp_delay > 0) shadow[rd] = alu_fn(op[2:0], shadow[rd], shadow[rs]);
    end else if (op == OP_MOVE)  shadow[rd] = shadow[rs];
    else if (op == OP_LOADI)     shadow[rd] = imm;
    else if (op == OP_OUT)       exp_out_q.push_back(shadow[rd]);
    @(posedge clk);
  endtask

  task automatic wait_idle(output int lows);
    @(negedge clk);
    instr_valid = 1'b0;
    lows = 0;
    while (!instr_ready && lows < 200) begin
      lows++;
      @(negedge clk);
    end
    if (!instr_ready) check("idle_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic w_issue(input logic [3:0] op, input int rd, input int rs, input logic [15:0] imm);
    int n = 0;
    @(negedge clk);
    w_valid = 1'b1;
    w_instr = {op, 3'(rd), 3'(rs)};
    w_imm   = imm;
    while (!w_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!w_ready) check("wide_ready_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  initial begin
    int l, s0, n;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; imm_data = '0; done_inj = 1'b0;
    w_valid = 1'b0; w_instr = '0; w_imm = '0; w_done = 1'b0; w_res_full = '0;
    resp_delay = 3;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_busy", {30'd0, instr_ready, busy}, 32'b10);
    check("rst_outputs", {alu_start, out_valid, err_illegal, err_timeout, alu_op, out_data, alu_a, alu_b},
          32'd0);
    rst_n = 1'b1;

    // Load operands, ADD with done in the third wait cycle (ready back after DECODE + 3 waits)
    issue(OP_LOADI, 1, 0, 8'h05, l);
    issue(OP_LOADI, 2, 0, 8'h03, l);
    check("loadi_busy_cycles", l, 1);
    s0 = start_cnt;
    issue(OP_ADD, 1, 2, 8'h00, l);
    issue(OP_OUT, 1, 0, 8'h00, l);
    check("add_busy_cycles", l, 4);
    check("add_start_pulses", start_cnt - s0, 1);

    // MOVE then OUT: one busy cycle each
    issue(OP_MOVE, 3, 1, 8'h00, l);
    check("out_busy_cycles", l, 1);
    issue(OP_OUT, 3, 0, 8'h00, l);
    check("move_busy_cycles", l, 1);

    // Illegal opcodes leave registers untouched, flag is sticky
    issue(4'b1110, 1, 2, 8'hAA, l);
    issue(4'b1111, 2, 1, 8'hBB, l);
    check("illegal_busy_cycles", l, 1);
    issue(OP_NOP, 0, 0, 8'h00, l);
    check("err_illegal_set", err_illegal, 1);
    issue(OP_OUT, 1, 0, 8'h00, l);
    issue(OP_OUT, 2, 0, 8'h00, l);
    check("err_illegal_sticky", err_illegal, 1);

    // Each ALU function with a different response delay; delay 1 = done alongside start
    issue(OP_LOADI, 0, 0, 8'h0C, l);
    for (int op = 1; op < 8; op++) begin
      resp_delay = op;
      issue(4'(op), 0, 2, 8'h00, l);
      issue(OP_OUT, 0, 0, 8'h00, l);
      check("alu_busy_cycles", l, 1 + op);
    end
    resp_delay = 2;
    issue(OP_ADD, 2, 2, 8'h00, l);
    issue(OP_OUT, 2, 0, 8'h00, l);

    // Done arriving in the last allowed wait cycle still writes back
    resp_delay = 15;
    issue(OP_ADD, 0, 2, 8'h00, l);
    issue(OP_OUT, 0, 0, 8'h00, l);
    check("late_done_busy_cycles", l, 16);
    check("late_done_no_timeout", err_timeout, 0);

    // Stray done while idle is ignored
    wait_idle(l);
    @(negedge clk) done_inj = 1'b1;
    @(negedge clk) done_inj = 1'b0;
    issue(OP_OUT, 0, 0, 8'h00, l);

    // Timeout: next instruction held valid is not taken until the unit is free again
    resp_delay = 0;
    issue(OP_SUB, 1, 2, 8'h00, l);
    issue(OP_OUT, 1, 0, 8'h00, l);
    check("timeout_busy_cycles", l, 16);
    check("err_timeout_set", err_timeout, 1);
    issue(OP_NOP, 0, 0, 8'h00, l);
    check("err_timeout_sticky", err_timeout, 1);

    // Reset during ALU_WAIT, then a late done: nothing must be written back
    issue(OP_LOADI, 1, 0, 8'h55, l);
    issue(OP_ADD, 1, 2, 8'h00, l);
    repeat (4) @(negedge clk);
    check("in_alu_wait_busy", busy, 1);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    @(negedge clk) rst_n = 1'b1;
    done_inj = 1'b1;
    @(negedge clk) done_inj = 1'b0;
    check("post_rst_ready_busy", {30'd0, instr_ready, busy}, 32'b10);
    check("post_rst_outputs", {alu_start, out_valid, err_illegal, err_timeout, alu_op, out_data, alu_a, alu_b},
          32'd0);
    issue(OP_OUT, 1, 0, 8'h00, l);
    wait_idle(l);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_out_q.size() + exp_alu_q.size(), 0);

    // Wide instance: 10-bit instructions, writeback truncated to 16 bits
    w_issue(OP_LOADI, 7, 0, 16'hFFFF);
    w_issue(OP_ADD, 7, 7, 16'h0000);
    n = 0;
    while (!w_start && n < 50) begin n++; @(negedge clk); end
    check("wide_start_seen", w_start, 1);
    check("wide_operands", {w_a, w_b}, 32'hFFFF_FFFF);
    w_done = 1'b1;
    w_res_full = 17'h1FFFE;
    @(negedge clk) w_done = 1'b0;
    w_issue(OP_OUT, 7, 0, 16'h0000);
    n = 0;
    while (!w_out_valid && n < 50) begin n++; @(negedge clk); end
    check("wide_out_valid", w_out_valid, 1);
    check("wide_truncated", {16'd0, w_out_data}, 32'h0000_FFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
